// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter that sequences one operation at a time through
// a shared combinational ALU and returns the result on the granted port.
module alu_arbiter #(
  parameter int WIDTH         = 16,
  parameter int PRIORITY_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic   last_grant;
  logic   sel;
  logic   accept;
  logic   rsp_hs;
  logic   op_illegal;

  // Port selection: a lone valid port wins; ties go round-robin or to port 0.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid)
      sel = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
    else
      sel = req1_valid;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign rsp_hs     = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);
  assign op_illegal = (alu_op == 2'b11);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= sel ? req1_a  : req0_a;
            alu_b      <= sel ? req1_b  : req0_b;
            alu_op     <= sel ? req1_op : req0_op;
            grant      <= sel;
            last_grant <= sel;
          end
        end
        EXEC: begin
          if (op_illegal)
            alu_op <= 2'b00;
          if (!grant) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= op_illegal ? '0 : alu_result;
            rsp0_err   <= op_illegal;
          end else begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= op_illegal ? '0 : alu_result;
            rsp1_err   <= op_illegal;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share stimulus; a small ALU model closes the loop on each.
module tb_alu_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_op = '0, req1_op = '0;

  logic a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp0_err, a_rsp1_err, a_busy, a_grant;
  logic b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err, b_busy, b_grant;
  logic [W-1:0] a_rsp0_data, a_rsp1_data, a_alu_a, a_alu_b, a_alu_result;
  logic [W-1:0] b_rsp0_data, b_rsp1_data, b_alu_a, b_alu_b, b_alu_result;
  logic [1:0] a_alu_op, b_alu_op;

  // Selected-instance view used by all checks.
  logic sel_dut = 1'b0;
  logic m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_rsp0_err, m_rsp1_err, m_busy, m_grant;
  logic [W-1:0] m_rsp0_data, m_rsp1_data, m_alu_a;
  logic [1:0] m_alu_op;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Reserved op returns a^b so a result leaking through is visible.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign a_alu_result = alu_model(a_alu_a, a_alu_b, a_alu_op);
  assign b_alu_result = alu_model(b_alu_a, b_alu_b, b_alu_op);

  alu_arbiter #(.WIDTH(W), .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(a_rsp0_data), .rsp0_err(a_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(a_rsp1_data), .rsp1_err(a_rsp1_err),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_op(a_alu_op), .alu_result(a_alu_result),
    .busy(a_busy), .grant(a_grant)
  );

  alu_arbiter #(.WIDTH(W), .PRIORITY_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(b_rsp0_data), .rsp0_err(b_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(b_rsp1_data), .rsp1_err(b_rsp1_err),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_op(b_alu_op), .alu_result(b_alu_result),
    .busy(b_busy), .grant(b_grant)
  );

  assign m_req0_ready = sel_dut ? b_req0_ready : a_req0_ready;
  assign m_req1_ready = sel_dut ? b_req1_ready : a_req1_ready;
  assign m_rsp0_valid = sel_dut ? b_rsp0_valid : a_rsp0_valid;
  assign m_rsp1_valid = sel_dut ? b_rsp1_valid : a_rsp1_valid;
  assign m_rsp0_err   = sel_dut ? b_rsp0_err   : a_rsp0_err;
  assign m_rsp1_err   = sel_dut ? b_rsp1_err   : a_rsp1_err;
  assign m_rsp0_data  = sel_dut ? b_rsp0_data  : a_rsp0_data;
  assign m_rsp1_data  = sel_dut ? b_rsp1_data  : a_rsp1_data;
  assign m_busy       = sel_dut ? b_busy       : a_busy;
  assign m_grant      = sel_dut ? b_grant      : a_grant;
  assign m_alu_a      = sel_dut ? b_alu_a      : a_alu_a;
  assign m_alu_op     = sel_dut ? b_alu_op     : a_alu_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the accepted port (or -1 on timeout) and cycles spent waiting.
  task automatic wait_accept(output int port, output int waited);
    port = -1;
    waited = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      #1;
      if (m_req0_ready) begin port = 0; return; end
      if (m_req1_ready) begin port = 1; return; end
      cycle();
      waited++;
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int p, w;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_alu_a", m_alu_a, 0);
    chk("rst_alu_op", m_alu_op, 0);
    chk("rst_rsp0_data", m_rsp0_data, 0);
    chk("rst_rsp0_valid", m_rsp0_valid, 0);
    chk("rst_grant", m_grant, 0);
    chk("rst_busy", m_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port 0 ADD 30+20, latency N -> N+2
    req0_a = 16'd30; req0_b = 16'd20; req0_op = 2'b01; req0_valid = 1'b1;
    wait_accept(p, w);
    chk("add_port", p, 0);
    chk("add_req1_ready", m_req1_ready, 0);
    cycle();
    req0_valid = 1'b0;
    chk("exec_busy", m_busy, 1);
    chk("exec_grant", m_grant, 0);
    chk("exec_alu_a", m_alu_a, 30);
    chk("exec_alu_op", m_alu_op, 1);
    chk("exec_rsp0_valid", m_rsp0_valid, 0);
    cycle();
    chk("add_rsp0_valid", m_rsp0_valid, 1);
    chk("add_rsp0_data", m_rsp0_data, 50);
    chk("add_rsp0_err", m_rsp0_err, 0);
    chk("add_rsp1_valid", m_rsp1_valid, 0);
    cycle();
    chk("add_done_valid", m_rsp0_valid, 0);
    chk("add_done_busy", m_busy, 0);

    // Round-robin, both ports continuously valid
    do_reset();
    req0_a = 16'd3;  req0_b = 16'd2;  req0_op = 2'b00; req0_valid = 1'b1;
    req1_a = 16'd30; req1_b = 16'd30; req1_op = 2'b10; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(p, w);
      chk("rr_grant", p, i % 2);
      chk("rr_latency", w, 0);
      cycle();
      cycle();
      chk("rr_rsp_valid", (p == 1) ? m_rsp1_valid : m_rsp0_valid, 1);
      chk("rr_rsp_data", (p == 1) ? m_rsp1_data : m_rsp0_data, (p == 1) ? 0 : 2);
      cycle();
    end

    // Fixed priority instance
    sel_dut = 1'b1;
    do_reset();
    req0_a = 16'd1; req0_b = 16'd2; req0_op = 2'b01; req0_valid = 1'b1;
    req1_a = 16'd9; req1_b = 16'd4; req1_op = 2'b10; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(p, w);
      chk("fp_grant", p, 0);
      chk("fp_req1_ready", m_req1_ready, 0);
      cycle();
      if (i == 2) req0_valid = 1'b0;
      cycle();
      chk("fp_rsp0_data", m_rsp0_data, 3);
      cycle();
    end
    wait_accept(p, w);
    chk("fp_port1_grant", p, 1);
    cycle();
    req1_valid = 1'b0;
    cycle();
    chk("fp_rsp1_data", m_rsp1_data, 5);
    cycle();
    sel_dut = 1'b0;

    // SUB wrap and reserved op
    do_reset();
    req1_a = 16'd3; req1_b = 16'd5; req1_op = 2'b10; req1_valid = 1'b1;
    wait_accept(p, w);
    chk("sub_port", p, 1);
    cycle();
    req1_valid = 1'b0;
    cycle();
    chk("sub_rsp1_data", m_rsp1_data, 16'hFFFE);
    chk("sub_rsp1_err", m_rsp1_err, 0);
    cycle();
    req0_a = 16'd7; req0_b = 16'd9; req0_op = 2'b11; req0_valid = 1'b1;
    wait_accept(p, w);
    cycle();
    req0_valid = 1'b0;
    chk("ill_exec_op", m_alu_op, 3);
    cycle();
    chk("ill_rsp0_valid", m_rsp0_valid, 1);
    chk("ill_rsp0_err", m_rsp0_err, 1);
    chk("ill_rsp0_data", m_rsp0_data, 0);
    chk("ill_alu_op", m_alu_op, 0);
    cycle();

    // Response back-pressure with a pending port 1 request
    do_reset();
    rsp0_ready = 1'b0;
    req0_a = 16'd100; req0_b = 16'd23; req0_op = 2'b01; req0_valid = 1'b1;
    req1_a = 16'hF0F0; req1_b = 16'hFF00; req1_op = 2'b00; req1_valid = 1'b1;
    wait_accept(p, w);
    chk("bp_port", p, 0);
    cycle();
    req0_valid = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rsp0_valid", m_rsp0_valid, 1);
      chk("bp_rsp0_data", m_rsp0_data, 123);
      chk("bp_busy", m_busy, 1);
      chk("bp_req1_ready", m_req1_ready, 0);
      cycle();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("hs_no_accept", m_req1_ready, 0);
    cycle();
    #1;
    chk("hs_rsp0_dropped", m_rsp0_valid, 0);
    chk("hs_req1_ready", m_req1_ready, 1);
    cycle();
    req1_valid = 1'b0;
    cycle();
    chk("bp_rsp1_data", m_rsp1_data, 16'hF000);
    cycle();

    // Reset during EXEC
    do_reset();
    req1_a = 16'h1234; req1_b = 16'd1; req1_op = 2'b01; req1_valid = 1'b1;
    wait_accept(p, w);
    cycle();
    req1_valid = 1'b0;
    chk("mid_busy", m_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_alu_a", m_alu_a, 0);
    chk("mid_busy_clr", m_busy, 0);
    chk("mid_grant", m_grant, 0);
    chk("mid_alu_op", m_alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_rsp", m_rsp0_valid | m_rsp1_valid, 0);
      cycle();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_tie_req0", m_req0_ready, 1);
    chk("mid_tie_req1", m_req1_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
